ksa_pipe_adder: RTL
===================

# ksa_pipe_adder

Parametrised, pipelined Kogge-Stone adder with valid/ready handshaking on both sides. It generalises the team's single-bit pre-processing, prefix (group propagate/generate) and post-processing cells to WIDTH bits. Pipeline registers sit at a configurable prefix-level spacing. The block sits in the datapath wherever a streaming, timing-closed wide adder is needed, with full backpressure and bubble collapse.

## Interface
- WIDTH, 32, operand/sum width; WIDTH >= 2, need not be a power of two
- PIPE_EVERY, 1, number of prefix levels between pipeline registers; 1 <= PIPE_EVERY <= LEVELS

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- sub  in  1  subtract select (present only with KSA_SUB_EN)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out

## Operation
- LEVELS = clog2(WIDTH); prefix level k (1..LEVELS) combines node i with node i-2^(k-1) when i >= 2^(k-1), otherwise passes through.
- Prefix operator: g = g_hi | (p_hi & g_lo); p = p_hi & p_lo.
- Carry-in is folded in as generate node -1: g[-1] = cin, p[-1] = 0.
- Stage 0 register: per bit p = a^b, g = a&b, plus cin. Also carries the original p vector forward for the sum.
- Stage registers 1..S, where S = ceil(LEVELS/PIPE_EVERY). Each holds (G,P,p_orig) after PIPE_EVERY levels; the last group may hold fewer levels.
- Output register: sum[i] = p_orig[i] ^ C[i], where C[0] = cin and C[i] = G[i-1:-1]. cout = G[WIDTH-1:-1].
- Arithmetic is modulo 2^WIDTH; cout is the unsigned carry.
- Each stage j has a valid bit v[j]. It loads when its ready is high: rdy[j] = !v[j] | rdy[j+1]. The output stage uses rdy = !out_valid | out_ready.
- in_ready = rdy[0] & !rst. A beat transfers when in_valid & in_ready.
- Bubbles collapse: an empty stage always accepts from upstream, even while downstream is stalled.
- a, b, cin (and sub) need only be valid in the transfer cycle.
- Results leave in acceptance order, with no loss and no duplication.

## Timing
- Latency LAT = S + 2 cycles from the input transfer edge to out_valid, with an empty pipeline and out_ready = 1.
  - WIDTH=32, PIPE_EVERY=1: 7 cycles.
  - WIDTH=32, PIPE_EVERY=5: 3 cycles.
  - WIDTH=8, PIPE_EVERY=1: 5 cycles.
- Throughput is 1 beat/cycle while out_ready = 1.
- Capacity is LAT beats. With out_ready held at 0, exactly LAT beats are accepted, then in_ready = 0.
- out_ready low holds sum/cout/out_valid stable.
- Simultaneous out-transfer and in-transfer on a full pipeline is allowed. in_ready depends combinationally on out_ready.
- Reset (asserted at any time):
  - All valid bits clear immediately; out_valid = 0, sum = 0, cout = 0, all stage data = 0.
  - In-flight beats are discarded.
  - in_ready = 0 while rst = 1 and is 1 in the first cycle after release.

## Configuration
- KSA_SUB_EN defined:
  - The sub port exists and is registered with the beat.
  - sub = 1 uses b' = ~b and forces the effective carry-in to 1, ignoring cin. The result is a - b; cout = 1 means no borrow.
  - sub = 0 is the normal add.
- KSA_SUB_EN undefined: there is no sub port and the block always adds with cin.

## Structure
- Package ksa_pkg holds:
  - function ksa_levels(width), returning clog2.
  - function ksa_latency(width, pipe_every).
  - typedef ksa_pg_t (p, g bit pair).
- Sub-module ksa_prefix_stage (combinational): one prefix level, parameterised by WIDTH and DIST = 2^(k-1). It is instantiated LEVELS times via generate.
- Pipeline registers and valid/ready chain live in ksa_pipe_adder.

## Test plan
- WIDTH=8, PIPE_EVERY=1, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, out_valid exactly 5 cycles after transfer.
- WIDTH=32, 1000 random beats, in_valid and out_ready both held 1 -> one result/cycle, in order, bit-exact versus a+b+cin.
- WIDTH=32, PIPE_EVERY=1, out_ready=0, in_valid=1 continuous -> 7 beats accepted then in_ready=0. Release out_ready -> all 7 results in order, no duplicates.
- Random in_valid/out_ready toggling (50%) -> scoreboard matches, no loss; a stalled result holds sum stable.
- rst pulse while 3 beats are in flight -> out_valid=0 asynchronously, no stale result after release, next beat has latency LAT.
- WIDTH=13, PIPE_EVERY=2 (LAT=4): a=0x1FFF, b=0x0001 -> sum=0, cout=1. With KSA_SUB_EN, WIDTH=8, sub=1: a=5, b=7 -> sum=0xFE, cout=0; a=7, b=5 -> sum=0x02, cout=1.

Source files
------------

// File: rtl/ksa_pkg.sv
// ksa_pkg: shared types and elaboration-time helpers for the pipelined
// Kogge-Stone adder.
//   ksa_pg_t     - one prefix node (propagate, generate)
//   ksa_levels   - number of prefix levels, clog2(width)
//   ksa_stages   - number of prefix pipeline registers, ceil(levels/pipe_every)
//   ksa_latency  - beat latency and capacity, stages + 2
package ksa_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } ksa_pg_t;

  function automatic int ksa_levels(input int width);
    return $clog2(width);
  endfunction

  function automatic int ksa_stages(input int width, input int pipe_every);
    return (ksa_levels(width) + pipe_every - 1) / pipe_every;
  endfunction

  function automatic int ksa_latency(input int width, input int pipe_every);
    return ksa_stages(width, pipe_every) + 2;
  endfunction

endpackage

// File: rtl/ksa_prefix_stage.sv
// ksa_prefix_stage: one combinational Kogge-Stone prefix level.
// Node n is combined with node n-DIST when that node exists, otherwise it
// passes through unchanged. Node 0 is the carry-in node, node i+1 is bit i.
//   pg_i  in   WIDTH+1 nodes entering this level
//   pg_o  out  WIDTH+1 nodes leaving this level
module ksa_prefix_stage
  import ksa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  ksa_pg_t [WIDTH:0] pg_i,
  output ksa_pg_t [WIDTH:0] pg_o
);

  for (genvar n = 0; n <= WIDTH; n++) begin : g_node
    if (n >= DIST) begin : g_op
      assign pg_o[n].g = pg_i[n].g | (pg_i[n].p & pg_i[n-DIST].g);
      assign pg_o[n].p = pg_i[n].p & pg_i[n-DIST].p;
    end else begin : g_pass
      assign pg_o[n] = pg_i[n];
    end
  end

endmodule

// File: rtl/ksa_pipe_adder.sv
// ksa_pipe_adder: pipelined Kogge-Stone adder with valid/ready on both sides.
// Register chain: stage 0 (bit p/g + carry-in node), prefix stages 1..S
// (PIPE_EVERY levels each, last one may hold fewer), output register.
// Latency and capacity are S+2 beats; empty stages always accept (bubble
// collapse) and a stalled output holds sum/cout/out_valid.
// Optional feature: define KSA_SUB_EN to add the sub port (a - b).
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  beat accepted this cycle (when in_valid)
//   a, b       in   operands, WIDTH bits
//   cin        in   carry-in (ignored when sub = 1)
//   sub        in   subtract select (KSA_SUB_EN only)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   sum        out  result, WIDTH bits
//   cout       out  unsigned carry-out (1 = no borrow when subtracting)
module ksa_pipe_adder
  import ksa_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PIPE_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef KSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = ksa_levels(WIDTH);
  localparam int S      = ksa_stages(WIDTH, PIPE_EVERY);

  // Index 0 is the carry-in node (-1), index i+1 is bit i.
  typedef ksa_pg_t [WIDTH:0] node_vec_t;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef KSA_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  node_vec_t pg0_d;

  // NOTE: every field of pg0_d is written on each evaluation, so no latch.
  always_comb begin
    pg0_d[0].p = 1'b0;
    pg0_d[0].g = cin_eff;
    for (int i = 0; i < WIDTH; i++) begin
      pg0_d[i+1].p = a[i] ^ b_eff[i];
      pg0_d[i+1].g = a[i] & b_eff[i];
    end
  end

  node_vec_t        stg_pg_q [S+1];
  logic [WIDTH-1:0] stg_p_q  [S+1];
  logic [S:0]       stg_v_q;

  node_vec_t lvl_in  [1:LEVELS];
  node_vec_t lvl_out [1:LEVELS];
  node_vec_t grp_out [1:S];

  // The first level of each group starts from a stage register; the rest
  // chain combinationally from the previous level.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_level
    if ((l - 1) % PIPE_EVERY == 0) begin : g_from_reg
      assign lvl_in[l] = stg_pg_q[(l-1)/PIPE_EVERY];
    end else begin : g_chain
      assign lvl_in[l] = lvl_out[l-1];
    end
    ksa_prefix_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << (l - 1))
    ) u_stage (
      .pg_i (lvl_in[l]),
      .pg_o (lvl_out[l])
    );
  end

  for (genvar j = 1; j <= S; j++) begin : g_group
    localparam int LAST = (j * PIPE_EVERY < LEVELS) ? j * PIPE_EVERY : LEVELS;
    assign grp_out[j] = lvl_out[LAST];
  end

  // Ready chain rdy[j] = !v[j] | rdy[j+1] unrolled: a stage may load when the
  // output drains or any stage from it downward has a hole.
  logic       rdy_out;
  logic [S:0] rdy;

  assign rdy_out = ~out_valid | out_ready;
  for (genvar j = 0; j <= S; j++) begin : g_rdy
    assign rdy[j] = rdy_out | ~(&stg_v_q[S:j]);
  end

  assign in_ready = rdy[0] & ~rst;

  // Output: C[i] is node i after the last level. With WIDTH+1 nodes but only
  // clog2(WIDTH) levels, the top node can stop one short of the carry-in
  // node, so cout folds it in explicitly (P is 0 whenever it did reach it).
  node_vec_t        fin;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             unused_fin_p;

  assign fin = stg_pg_q[S];

  always_comb begin
    unused_fin_p = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i]     = stg_p_q[S][i] ^ fin[i].g;
      unused_fin_p = unused_fin_p ^ fin[i].p;
    end
    cout_d = fin[WIDTH].g | (fin[WIDTH].p & fin[0].g);
  end

  // NOTE: pipeline data is reset too, so sum/cout read 0 during and after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_v_q   <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      for (int j = 0; j <= S; j++) begin
        stg_pg_q[j] <= '0;
        stg_p_q[j]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample the pre-edge
      // value of its upstream neighbour, independent of statement order.
      if (rdy[0]) begin
        stg_v_q[0] <= in_valid;
        if (in_valid) begin
          stg_pg_q[0] <= pg0_d;
          stg_p_q[0]  <= a ^ b_eff;
        end
      end
      for (int j = 1; j <= S; j++) begin
        if (rdy[j]) begin
          stg_v_q[j] <= stg_v_q[j-1];
          if (stg_v_q[j-1]) begin
            stg_pg_q[j] <= grp_out[j];
            stg_p_q[j]  <= stg_p_q[j-1];
          end
        end
      end
      if (rdy_out) begin
        out_valid <= stg_v_q[S];
        if (stg_v_q[S]) begin
          sum  <= sum_d;
          cout <= cout_d;
        end
      end
    end
  end

endmodule
